m_w_reg: RTL and testbench

M_W_REG -- requirements
Module: m_w_reg

---
 rtl/m_w_reg.sv | 90 +++++++++
 tb/tb_m_w_reg.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/m_w_reg.sv
// M/W pipeline register: carries the memory-stage results into write-back,
// derives the GRF write enable/data and counts retired instructions.
module m_w_reg #(
    parameter logic [31:0] RESET_PC      = 32'h0000_3000,
    parameter logic [31:0] RETIRED_RESET = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        en,
    input  logic        flush,
    input  logic        M_valid,
    input  logic [31:0] M_instr,
    input  logic [31:0] M_PC,
    input  logic [31:0] M_ALUout,
    input  logic [31:0] M_DMout,
    input  logic [4:0]  M_A3,
    input  logic [1:0]  M_Tnew,
    output logic [31:0] W_instr,
    output logic [31:0] W_PC,
    output logic [31:0] W_ALUout,
    output logic [31:0] W_DMout,
    output logic [4:0]  W_A3,
    output logic [1:0]  W_Tnew,
    output logic        W_valid,
    output logic        W_RegWrite,
    output logic [31:0] W_WD,
    output logic [31:0] W_retired
);
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_LUI   = 6'b001111;
    localparam logic [5:0] OP_JAL   = 6'b000011;
    localparam logic [5:0] FN_ADD   = 6'b100000;
    localparam logic [5:0] FN_SUB   = 6'b100010;

    logic [1:0] tnew_dec;
    assign tnew_dec = (M_Tnew == 2'd0) ? 2'd0 : M_Tnew - 2'd1;

    // Flush beats stall beats load; a flushed slot still tracks M_PC.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            W_instr   <= '0;
            W_PC      <= RESET_PC;
            W_ALUout  <= '0;
            W_DMout   <= '0;
            W_A3      <= '0;
            W_Tnew    <= '0;
            W_valid   <= 1'b0;
            W_retired <= RETIRED_RESET;
        end else if (flush) begin
            W_instr  <= '0;
            W_PC     <= M_PC;
            W_ALUout <= '0;
            W_DMout  <= '0;
            W_A3     <= '0;
            W_Tnew   <= '0;
            W_valid  <= 1'b0;
        end else if (en) begin
            W_instr  <= M_instr;
            W_PC     <= M_PC;
            W_ALUout <= M_ALUout;
            W_DMout  <= M_DMout;
            W_A3     <= M_A3;
            W_Tnew   <= tnew_dec;
            W_valid  <= M_valid;
            if (M_valid && (M_instr != 32'd0))
                W_retired <= W_retired + 32'd1;
        end
    end

    logic [5:0] op, funct;
    logic       is_add, is_sub, is_ori, is_lw, is_lui, is_jal;
    assign op     = W_instr[31:26];
    assign funct  = W_instr[5:0];
    assign is_add = (op == OP_RTYPE) && (funct == FN_ADD);
    assign is_sub = (op == OP_RTYPE) && (funct == FN_SUB);
    assign is_ori = (op == OP_ORI);
    assign is_lw  = (op == OP_LW);
    assign is_lui = (op == OP_LUI);
    assign is_jal = (op == OP_JAL);

    assign W_RegWrite = W_valid && (W_A3 != 5'd0) &&
                        (is_add || is_sub || is_ori || is_lw || is_lui || is_jal);

    // jal links PC+8; the add wraps naturally at 32 bits.
    assign W_WD = is_lw  ? W_DMout :
                  is_jal ? W_PC + 32'd8 :
                           W_ALUout;
endmodule

// File: tb/tb_m_w_reg.sv
// Directed bench for m_w_reg: a write-back model checked every cycle, plus
// hand-computed expectations at the interesting points.
module tb_m_w_reg;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        en = 1'b1, flush = 1'b0, M_valid = 1'b0;
    logic [31:0] M_instr = '0, M_PC = 32'h3000, M_ALUout = '0, M_DMout = '0;
    logic [4:0]  M_A3 = '0;
    logic [1:0]  M_Tnew = '0;

    logic [31:0] W_instr, W_PC, W_ALUout, W_DMout, W_WD, W_retired;
    logic [4:0]  W_A3;
    logic [1:0]  W_Tnew;
    logic        W_valid, W_RegWrite;

    logic [31:0] x_instr, x_PC, x_ALUout, x_DMout, x_WD, x_retired;
    logic [4:0]  x_A3;
    logic [1:0]  x_Tnew;
    logic        x_valid, x_RegWrite;

    int ntests = 0, nfail = 0;
    bit chk_on = 1'b0;

    m_w_reg dut (
        .clk(clk), .reset(reset), .en(en), .flush(flush), .M_valid(M_valid),
        .M_instr(M_instr), .M_PC(M_PC), .M_ALUout(M_ALUout), .M_DMout(M_DMout),
        .M_A3(M_A3), .M_Tnew(M_Tnew),
        .W_instr(W_instr), .W_PC(W_PC), .W_ALUout(W_ALUout), .W_DMout(W_DMout),
        .W_A3(W_A3), .W_Tnew(W_Tnew), .W_valid(W_valid), .W_RegWrite(W_RegWrite),
        .W_WD(W_WD), .W_retired(W_retired)
    );

    // Second copy whose counter starts one below wrap.
    m_w_reg #(.RETIRED_RESET(32'hFFFF_FFFF)) dut2 (
        .clk(clk), .reset(reset), .en(en), .flush(flush), .M_valid(M_valid),
        .M_instr(M_instr), .M_PC(M_PC), .M_ALUout(M_ALUout), .M_DMout(M_DMout),
        .M_A3(M_A3), .M_Tnew(M_Tnew),
        .W_instr(x_instr), .W_PC(x_PC), .W_ALUout(x_ALUout), .W_DMout(x_DMout),
        .W_A3(x_A3), .W_Tnew(x_Tnew), .W_valid(x_valid), .W_RegWrite(x_RegWrite),
        .W_WD(x_WD), .W_retired(x_retired)
    );

    always #5 clk = ~clk;

    // Model: the W slot as a record plus a retire tally.
    typedef struct {
        logic [31:0] instr, pc, alu, dm;
        logic [4:0]  a3;
        int          tnew;
        logic        valid;
        longint      retired;
    } wslot_t;
    wslot_t m;

    function automatic void model_reset();
        m.instr = 0; m.pc = 32'h3000; m.alu = 0; m.dm = 0;
        m.a3 = 0; m.tnew = 0; m.valid = 0; m.retired = 0;
    endfunction

    initial model_reset();

    always @(posedge clk or negedge reset) begin
        if (!reset) model_reset();
        else if (flush) begin
            m.instr = 0; m.alu = 0; m.dm = 0; m.a3 = 0; m.tnew = 0; m.valid = 0;
            m.pc = M_PC;
        end else if (en) begin
            m.instr = M_instr; m.pc = M_PC; m.alu = M_ALUout; m.dm = M_DMout;
            m.a3 = M_A3; m.valid = M_valid;
            m.tnew = (int'(M_Tnew) > 0) ? int'(M_Tnew) - 1 : 0;
            if (M_valid && M_instr != 0) m.retired = m.retired + 1;
        end
    end

    function automatic string mnem(logic [31:0] i);
        logic [5:0] o, f;
        o = i[31:26]; f = i[5:0];
        if (i == 0) return "nop";
        if (o == 6'd0 && f == 6'h20) return "add";
        if (o == 6'd0 && f == 6'h22) return "sub";
        if (o == 6'h0D) return "ori";
        if (o == 6'h23) return "lw";
        if (o == 6'h0F) return "lui";
        if (o == 6'h03) return "jal";
        return "other";
    endfunction

    function automatic logic exp_rw();
        string s;
        s = mnem(m.instr);
        return m.valid && m.a3 != 0 &&
               (s == "add" || s == "sub" || s == "ori" || s == "lw" || s == "lui" || s == "jal");
    endfunction

    function automatic logic [31:0] exp_wd();
        string s;
        s = mnem(m.instr);
        if (s == "lw")  return m.dm;
        if (s == "jal") return 32'((64'(m.pc) + 64'd8) % 64'h1_0000_0000);
        return m.alu;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        ntests++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_on) begin
            chk("instr",    W_instr,   m.instr);
            chk("pc",       W_PC,      m.pc);
            chk("aluout",   W_ALUout,  m.alu);
            chk("dmout",    W_DMout,   m.dm);
            chk("a3",       32'(W_A3), 32'(m.a3));
            chk("tnew",     32'(W_Tnew), 32'(m.tnew));
            chk("valid",    32'(W_valid), 32'(m.valid));
            chk("regwrite", 32'(W_RegWrite), 32'(exp_rw()));
            chk("wd",       W_WD,      exp_wd());
            chk("retired",  W_retired, 32'(m.retired));
            chk("retired_wrap", x_retired, 32'(m.retired + 64'hFFFF_FFFF));
        end
    end

    task automatic load(input logic v, input logic [31:0] ins, input logic [31:0] pc,
                        input logic [31:0] alu, input logic [31:0] dm,
                        input logic [4:0] a3, input logic [1:0] tn,
                        input logic e, input logic f);
        M_valid = v; M_instr = ins; M_PC = pc; M_ALUout = alu; M_DMout = dm;
        M_A3 = a3; M_Tnew = tn; en = e; flush = f;
        @(posedge clk);
        @(negedge clk);
    endtask

    localparam logic [31:0] I_LW  = 32'h8C05_0000, I_JAL = 32'h0C00_0C02,
                            I_ORI = 32'h3422_0005, I_ADD = 32'h0022_1820,
                            I_SUB = 32'h0022_1822, I_SW  = 32'hAC05_0000,
                            I_BEQ = 32'h1022_0003, I_LUI = 32'h3C01_1234,
                            I_JR  = 32'h03E0_0008, I_UNK = 32'hFC00_0000;

    initial begin
        #1 reset = 1'b0;
        #1 chk_on = 1'b1;
        @(negedge clk); @(negedge clk);
        chk("rst_pc", W_PC, 32'h3000);
        chk("rst_retired", W_retired, 32'd0);
        chk("rst_wd", W_WD, 32'd0);
        chk("rst_regwrite", 32'(W_RegWrite), 32'd0);
        reset = 1'b1;

        // invalid bubbles after reset only move W_PC
        load(0, 0, 32'h3004, 0, 0, 0, 0, 1, 0);
        chk("idle_pc", W_PC, 32'h3004);
        chk("idle_retired", W_retired, 32'd0);
        chk("idle_valid", 32'(W_valid), 32'd0);

        load(1, I_LW, 32'h3008, 32'h99, 32'h1234, 5, 1, 1, 0);
        chk("lw_rw", 32'(W_RegWrite), 32'd1);
        chk("lw_wd", W_WD, 32'h1234);
        chk("lw_tnew", 32'(W_Tnew), 32'd0);
        chk("lw_retired", W_retired, 32'd1);
        chk("wrap_retired", x_retired, 32'd0);

        load(1, I_JAL, 32'h3008, 32'h77, 0, 31, 0, 1, 0);
        chk("jal_wd", W_WD, 32'h3010);
        chk("jal_rw", 32'(W_RegWrite), 32'd1);
        chk("jal_tnew", 32'(W_Tnew), 32'd0);

        load(1, I_ORI, 32'h300C, 32'h55, 32'h66, 2, 1, 1, 0);
        for (int i = 0; i < 3; i++)
            load(1, I_LW, 32'h4000 + 32'(i), 32'hDEAD, 32'hBEEF, 9, 3, 0, 0);
        chk("stall_wd", W_WD, 32'h55);
        chk("stall_pc", W_PC, 32'h300C);
        chk("stall_retired", W_retired, 32'd3);
        load(1, I_LW, 32'h3010, 32'hDEAD, 32'hBEEF, 9, 3, 0, 1);
        chk("flush_valid", 32'(W_valid), 32'd0);
        chk("flush_instr", W_instr, 32'd0);
        chk("flush_rw", 32'(W_RegWrite), 32'd0);
        chk("flush_retired", W_retired, 32'd3);
        chk("flush_pc", W_PC, 32'h3010);

        load(1, I_ADD, 32'h3014, 32'h5, 0, 0, 3, 1, 0);
        chk("tnew3", 32'(W_Tnew), 32'd2);
        chk("add_a3zero_rw", 32'(W_RegWrite), 32'd0);
        chk("add_a3zero_ret", W_retired, 32'd4);
        load(1, I_SW, 32'h3018, 32'h8, 32'h9, 5, 2, 1, 0);
        chk("sw_rw", 32'(W_RegWrite), 32'd0);
        chk("sw_tnew", 32'(W_Tnew), 32'd1);

        load(1, I_SUB, 32'h301C, 32'h11, 0, 4, 1, 1, 0);
        load(1, I_LUI, 32'h3020, 32'h1234_0000, 0, 1, 1, 1, 0);
        load(1, I_BEQ, 32'h3024, 32'h22, 0, 3, 0, 1, 0);
        load(1, I_JR,  32'h3028, 32'h33, 0, 31, 0, 1, 0);
        load(1, I_UNK, 32'h302C, 32'h44, 0, 6, 2, 1, 0);
        load(1, I_JAL, 32'hFFFF_FFFC, 32'h0, 0, 31, 0, 1, 0);
        chk("jal_wrap_wd", W_WD, 32'h4);
        load(0, I_ORI, 32'h3030, 32'h12, 0, 8, 1, 1, 0);
        chk("invalid_rw", 32'(W_RegWrite), 32'd0);
        load(1, I_ORI, 32'h3034, 32'h13, 0, 8, 2, 1, 1);
        chk("flush_en_valid", 32'(W_valid), 32'd0);

        // reset dropped between edges while a flush/stall is requested
        load(1, I_ORI, 32'h3038, 32'h21, 0, 8, 2, 1, 0);
        en = 1'b0; flush = 1'b1;
        @(posedge clk);
        #2 reset = 1'b0;
        #1;
        chk("async_pc", W_PC, 32'h3000);
        chk("async_retired", W_retired, 32'd0);
        chk("async_valid", 32'(W_valid), 32'd0);
        chk("async_wd", W_WD, 32'd0);
        @(negedge clk);
        reset = 1'b1;
        load(1, I_LW, 32'h3040, 0, 32'hABCD, 7, 2, 1, 0);
        chk("post_rst_wd", W_WD, 32'hABCD);
        chk("post_rst_ret", W_retired, 32'd1);
        chk("post_rst_tnew", 32'(W_Tnew), 32'd1);

        chk_on = 1'b0;
        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end
endmodule
